decode_stage: RTL and testbench

- Registered, parametrised RV32I instruction decode stage with valid/ready handshakes on both sides.
- Sits between fetch and execute: decodes the instruction and reads the register file at acceptance.
- Produces sign-extended immediates, selected operands, an instruction class code and an illegal flag.
- A 2-entry skid buffer sustains one instruction per cycle under back-pressure; a flush input squashes in-flight entries.

---
 rtl/decode_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I decode stage between fetch and execute. An accepted
// instruction is decoded and its register operands are captured in the same
// cycle; the decoded entry appears on out_* one cycle later. A two-entry
// skid buffer (main + skid) keeps one instruction per cycle flowing under
// back-pressure, and flush squashes every held entry.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous squash of all held entries
//   in_valid/in_ready fetch-side handshake; in_instr, in_pc carry the word
//   rs1_addr/rs2_addr register file read addresses (combinational)
//   rs1_data/rs2_data register file read data
//   out_valid/out_ready execute-side handshake
//   out_pc, out_class, out_funct3, out_funct7b5, out_rd_addr, out_rd_we,
//   out_imm, out_opd1, out_opd2, out_store_data  decoded entry fields
//
// Optional feature (macro DECODE_STAGE_BYPASS_EN):
//   adds wb_we, wb_rd_addr, wb_data; a write-back to rs1/rs2 in the
//   acceptance cycle overrides the register file read data.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int OPD_LENGTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [REG_WIDTH-1:0]  rs1_data,
    input  logic [REG_WIDTH-1:0]  rs2_data,
`ifdef DECODE_STAGE_BYPASS_EN
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd_addr,
    input  logic [REG_WIDTH-1:0]  wb_data,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [3:0]            out_class,
    output logic [2:0]            out_funct3,
    output logic                  out_funct7b5,
    output logic [4:0]            out_rd_addr,
    output logic                  out_rd_we,
    output logic [OPD_LENGTH-1:0] out_imm,
    output logic [OPD_LENGTH-1:0] out_opd1,
    output logic [OPD_LENGTH-1:0] out_opd2,
    output logic [OPD_LENGTH-1:0] out_store_data
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_S       = 4'd3,
        CLS_B       = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } buf_state_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        cls_e                  cls;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic [4:0]            rd_addr;
        logic                  rd_we;
        logic [OPD_LENGTH-1:0] imm;
        logic [OPD_LENGTH-1:0] opd1;
        logic [OPD_LENGTH-1:0] opd2;
        logic [OPD_LENGTH-1:0] store_data;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    entry_t     dec;

    logic [REG_WIDTH-1:0]  rs1_val, rs2_val;
    logic [OPD_LENGTH-1:0] rs1_ext, rs2_ext, pc_ext;
    logic [31:0]           imm32;
    logic                  accept, consume;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

`ifdef DECODE_STAGE_BYPASS_EN
    // A result being written back this cycle is newer than the file contents.
    assign rs1_val = (wb_we && wb_rd_addr != 5'd0 && wb_rd_addr == rs1_addr) ? wb_data : rs1_data;
    assign rs2_val = (wb_we && wb_rd_addr != 5'd0 && wb_rd_addr == rs2_addr) ? wb_data : rs2_data;
`else
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    assign rs1_ext = OPD_LENGTH'(rs1_val);
    assign rs2_ext = OPD_LENGTH'(rs2_val);
    assign pc_ext  = OPD_LENGTH'(in_pc);

    // Decode of the instruction currently presented at the input.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        dec          = '0;
        imm32        = '0;
        dec.pc       = in_pc;
        dec.funct3   = in_instr[14:12];
        dec.funct7b5 = in_instr[30];
        dec.rd_addr  = in_instr[11:7];
        dec.cls      = CLS_ILLEGAL;

        // Every legal opcode ends in 2'b11, so a bad low pair lands in default.
        case (in_instr[6:0])
            OP_R: begin
                dec.cls  = CLS_R;
                dec.opd1 = rs1_ext;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec.cls  = (in_instr[6:0] == OP_IMM)  ? CLS_I :
                           (in_instr[6:0] == OP_LOAD) ? CLS_LOAD : CLS_JALR;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.opd1 = rs1_ext;
            end
            OP_STORE: begin
                dec.cls        = CLS_S;
                imm32          = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec.opd1       = rs1_ext;
                dec.store_data = rs2_ext;
            end
            OP_BR: begin
                dec.cls  = CLS_B;
                imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
                dec.opd1 = rs1_ext;
            end
            OP_JAL: begin
                dec.cls  = CLS_JAL;
                imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
                dec.opd1 = pc_ext;
            end
            OP_LUI: begin
                dec.cls = CLS_LUI;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                dec.cls  = CLS_AUIPC;
                imm32    = {in_instr[31:12], 12'b0};
                dec.opd1 = pc_ext;
            end
            default: dec.cls = CLS_ILLEGAL;
        endcase

        // R and ILLEGAL leave imm32 at zero, so their immediate reads as 0.
        dec.imm = OPD_LENGTH'($signed(imm32));

        if (dec.cls == CLS_R || dec.cls == CLS_B) begin
            dec.opd2 = rs2_ext;
        end else if (dec.cls != CLS_ILLEGAL) begin
            dec.opd2 = dec.imm;
        end

        dec.rd_we = (dec.cls != CLS_S) && (dec.cls != CLS_B) &&
                    (dec.cls != CLS_ILLEGAL) && (dec.rd_addr != 5'd0);
    end

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Skid buffer control: main always feeds the outputs, skid only fills
    // when a new entry arrives while main is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Only the state clears; main keeps its data so outputs hold.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end else if (consume) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entry registers are reset too (not just the state),
            // because the data outputs must read zero straight out of reset.
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc         = main_q.pc;
    assign out_class      = main_q.cls;
    assign out_funct3     = main_q.funct3;
    assign out_funct7b5   = main_q.funct7b5;
    assign out_rd_addr    = main_q.rd_addr;
    assign out_rd_we      = main_q.rd_we;
    assign out_imm        = main_q.imm;
    assign out_opd1       = main_q.opd1;
    assign out_opd2       = main_q.opd2;
    assign out_store_data = main_q.store_data;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage (default 32-bit parameters). A
// queue-based model predicts the buffered entries; a compare process checks
// every DUT output against it on each falling edge. Directed sequences pin
// the model with hand-computed values, then a randomized phase streams
// instructions with random handshakes and flushes.
// Honours DECODE_STAGE_BYPASS_EN when defined.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic [31:0] out_imm, out_opd1, out_opd2, out_store_data;
`ifdef DECODE_STAGE_BYPASS_EN
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd_addr = '0;
    logic [31:0] wb_data = '0;
`endif

    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.OPD_LENGTH(32), .REG_WIDTH(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef DECODE_STAGE_BYPASS_EN
        .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_imm(out_imm),
        .out_opd1(out_opd1), .out_opd2(out_opd2), .out_store_data(out_store_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic [31:0] opd1;
        logic [31:0] opd2;
        logic [31:0] sd;
    } exp_t;

    // Immediates built arithmetically: a sign mask shifted above the field.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] sgn;
        sgn    = {32{ins[31]}};
        e      = '0;
        e.pc   = pc;
        e.f3   = ins[14:12];
        e.f7b5 = ins[30];
        e.rd   = ins[11:7];
        e.cls  = 4'd15;
        case (ins[6:0])
            7'h33: begin e.cls = 4'd0; e.opd1 = a; e.opd2 = b; end
            7'h13, 7'h03, 7'h67: begin
                e.cls  = (ins[6:0] == 7'h13) ? 4'd1 : (ins[6:0] == 7'h03) ? 4'd2 : 4'd6;
                e.imm  = (sgn << 12) | 32'(ins[31:20]);
                e.opd1 = a; e.opd2 = e.imm;
            end
            7'h23: begin
                e.cls  = 4'd3;
                e.imm  = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
                e.opd1 = a; e.opd2 = e.imm; e.sd = b;
            end
            7'h63: begin
                e.cls  = 4'd4;
                e.imm  = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                e.opd1 = a; e.opd2 = b;
            end
            7'h6F: begin
                e.cls  = 4'd5;
                e.imm  = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
                e.opd1 = pc; e.opd2 = e.imm;
            end
            7'h37: begin e.cls = 4'd7; e.imm = ins & 32'hFFFFF000; e.opd2 = e.imm; end
            7'h17: begin e.cls = 4'd8; e.imm = ins & 32'hFFFFF000; e.opd1 = pc; e.opd2 = e.imm; end
            default: e.cls = 4'd15;
        endcase
        e.rd_we = !(e.cls inside {4'd3, 4'd4, 4'd15}) && (e.rd != 5'd0);
        return e;
    endfunction

    exp_t q[$];
    exp_t hold = '0;

    always @(posedge clk or posedge rst) begin : model_proc
        exp_t        e;
        logic [31:0] a, b;
        bit          acc, con;
        if (rst) begin
            q.delete();
            hold = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            a = regs[in_instr[19:15]];
            b = regs[in_instr[24:20]];
`ifdef DECODE_STAGE_BYPASS_EN
            if (wb_we && wb_rd_addr != 0 && wb_rd_addr == in_instr[19:15]) a = wb_data;
            if (wb_we && wb_rd_addr != 0 && wb_rd_addr == in_instr[24:20]) b = wb_data;
`endif
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            e   = model(in_instr, in_pc, a, b);
            if (con) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() > 0) hold = q[0];
        end
    end

    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("rs1_addr", 64'(rs1_addr), 64'(in_instr[19:15]));
        check("rs2_addr", 64'(rs2_addr), 64'(in_instr[24:20]));
        check("out_pc", 64'(out_pc), 64'(hold.pc));
        check("out_class", 64'(out_class), 64'(hold.cls));
        check("out_funct3", 64'(out_funct3), 64'(hold.f3));
        check("out_funct7b5", 64'(out_funct7b5), 64'(hold.f7b5));
        check("out_rd_addr", 64'(out_rd_addr), 64'(hold.rd));
        check("out_rd_we", 64'(out_rd_we), 64'(hold.rd_we));
        check("out_imm", 64'(out_imm), 64'(hold.imm));
        check("out_opd1", 64'(out_opd1), 64'(hold.opd1));
        check("out_opd2", 64'(out_opd2), 64'(hold.opd2));
        check("out_store_data", 64'(out_store_data), 64'(hold.sd));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        regs[3] = 32'd9;
        regs[4] = 32'd13;

        // Reset state
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_opd1", 64'(out_opd1), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        rst = 1'b0;
        step();

        // Back-to-back decodes with execute always ready
        in_valid = 1'b1; in_instr = enc_add(5'd2, 5'd3, 5'd4); in_pc = 32'd16;
        step();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_class", 64'(out_class), 64'd0);
        check("add_opd1", 64'(out_opd1), 64'd9);
        check("add_opd2", 64'(out_opd2), 64'd13);
        check("add_rd", 64'(out_rd_addr), 64'd2);
        check("add_rd_we", 64'(out_rd_we), 64'd1);
        in_instr = {12'hFFC, 5'd3, 3'b000, 5'd2, 7'b0010011}; in_pc = 32'd20;
        step();
        check("addi_class", 64'(out_class), 64'd1);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("addi_opd2", 64'(out_opd2), 64'hFFFF_FFFC);
        check("addi_opd1", 64'(out_opd1), 64'd9);
        in_instr = enc_jal(5'd3, 21'd80); in_pc = 32'd16;
        step();
        check("jal_class", 64'(out_class), 64'd5);
        check("jal_opd1", 64'(out_opd1), 64'd16);
        check("jal_opd2", 64'(out_opd2), 64'd80);
        check("jal_rd_we", 64'(out_rd_we), 64'd1);
        in_instr = {20'd2, 5'd10, 7'b0110111}; in_pc = 32'd20;
        step();
        check("lui_class", 64'(out_class), 64'd7);
        check("lui_opd1", 64'(out_opd1), 64'd0);
        check("lui_opd2", 64'(out_opd2), 64'h2000);
        in_instr = {20'd2, 5'd15, 7'b0010111}; in_pc = 32'd24;
        step();
        check("auipc_class", 64'(out_class), 64'd8);
        check("auipc_opd1", 64'(out_opd1), 64'd24);
        check("auipc_opd2", 64'(out_opd2), 64'h2000);
        in_instr = 32'h0; in_pc = 32'd28;
        step();
        check("ill_class", 64'(out_class), 64'd15);
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_rd_we", 64'(out_rd_we), 64'd0);
        check("ill_opd1", 64'(out_opd1), 64'd0);
        check("ill_opd2", 64'(out_opd2), 64'd0);
        check("ill_imm", 64'(out_imm), 64'd0);
        in_valid = 1'b0;
        step();

        // Back-pressure: three instructions with execute stalled
        out_ready = 1'b0; in_valid = 1'b1; in_instr = enc_add(5'd5, 5'd3, 5'd4);
        in_pc = 32'h100;
        step();
        check("bp_first_pc", 64'(out_pc), 64'h100);
        check("bp_first_ready", 64'(in_ready), 64'd1);
        in_pc = 32'h104;
        step();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_pc", 64'(out_pc), 64'h100);
        in_pc = 32'h108;
        step();
        check("bp_stable_pc", 64'(out_pc), 64'h100);
        check("bp_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_second_pc", 64'(out_pc), 64'h104);
        step();
        check("bp_third_pc", 64'(out_pc), 64'h108);
        check("bp_third_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush while full, with a new instruction offered
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
        step();
        in_pc = 32'h204;
        step();
        flush = 1'b1; in_pc = 32'h208;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_hold_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_reappear", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
        step();
        check("rstmid_valid_before", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_valid_drop", 64'(out_valid), 64'd0);
        check("rstmid_pc_clear", 64'(out_pc), 64'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        step();

`ifdef DECODE_STAGE_BYPASS_EN
        wb_we = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'd77;
        in_valid = 1'b1; in_instr = enc_add(5'd2, 5'd3, 5'd4); in_pc = 32'h400;
        step();
        check("byp_opd1", 64'(out_opd1), 64'd77);
        check("byp_opd2", 64'(out_opd2), 64'd13);
        wb_we = 1'b0; in_valid = 1'b0;
        step();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            r = $urandom();
            case ($urandom_range(0, 11))
                0:       in_instr = r;
                1:       in_instr = {r[31:2], 2'b01};
                default: in_instr = {r[31:7], ops[$urandom_range(0, 8)]};
            endcase
            in_pc = $urandom();
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom();
`ifdef DECODE_STAGE_BYPASS_EN
            wb_we      = $urandom_range(0, 1) == 1;
            wb_rd_addr = ($urandom_range(0, 1) == 1) ? in_instr[19:15] : 5'($urandom_range(0, 31));
            wb_data    = $urandom();
`endif
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
